// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction memory request/response bus for fetch_unit
interface fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch with 2-entry queue
// Optional static backward-branch prediction: define FETCH_STATIC_PREDICT_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.master  imem,
    input  logic          branch_taken_in,
    input  logic [31:0]   branch_target_in,
    input  logic          sel_stall,
    output logic [31:0]   instr_out,
    output logic [31:0]   pc_out,
    output logic          valid_out,
    output logic          pred_taken_out
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } state_t;

    typedef struct packed {
`ifdef FETCH_STATIC_PREDICT_EN
        logic        pred;
`endif
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] req_pc_q;
    logic [1:0]  count_q;
    entry_t      e0_q;
    entry_t      e1_q;
    entry_t      new_entry;

    logic        pop;
    logic        push;
    logic        issue;
    logic [1:0]  count_after_pop;

`ifdef FETCH_STATIC_PREDICT_EN
    logic        rsp_pred;
    logic [31:0] pred_target;

    // Unconditional backward B: the target is relative to the branch pc plus 8.
    assign rsp_pred    = (imem.imem_rdata[31:28] == 4'hE) &&
                         (imem.imem_rdata[27:24] == 4'hA) &&
                         imem.imem_rdata[23];
    assign pred_target = req_pc_q + 32'd8 +
                         {{6{imem.imem_rdata[23]}}, imem.imem_rdata[23:0], 2'b00};
`endif

    always_comb begin
        pop             = valid_out && !sel_stall && !branch_taken_in;
        count_after_pop = count_q - {1'b0, pop};
        issue           = (state_q == IDLE) && !branch_taken_in && (count_after_pop < 2'd2);
        push            = (state_q == WAIT) && imem.imem_rvalid && !branch_taken_in;

        new_entry       = '0;
        new_entry.instr = imem.imem_rdata;
        new_entry.pc    = req_pc_q;
`ifdef FETCH_STATIC_PREDICT_EN
        new_entry.pred  = rsp_pred;
`endif
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT;
                    pc_d    = pc_q + 32'd4;
                end
            end
            WAIT: begin
                if (imem.imem_rvalid) begin
                    state_d = IDLE;
                end else if (branch_taken_in) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem.imem_rvalid) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef FETCH_STATIC_PREDICT_EN
        if (push && rsp_pred) begin
            pc_d = pred_target;
        end
`endif
        if (branch_taken_in) begin
            pc_d = branch_target_in;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            req_pc_q <= 32'h0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            if (issue) begin
                req_pc_q <= pc_q;
            end
        end
    end

    // Head always lives in e0; a push lands behind whatever survives this cycle's pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= 2'd0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else if (branch_taken_in) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        e0_q <= new_entry;
                    end else begin
                        e1_q <= new_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    e0_q    <= e1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        e0_q <= new_entry;
                    end else begin
                        e0_q <= e1_q;
                        e1_q <= new_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign valid_out      = (count_q != 2'd0);
    assign instr_out      = e0_q.instr;
    assign pc_out         = e0_q.pc;
`ifdef FETCH_STATIC_PREDICT_EN
    assign pred_taken_out = e0_q.pred;
`else
    assign pred_taken_out = 1'b0;
`endif

    // Gated by reset so the bus is quiet while reset is held, even though the FSM sits in IDLE.
    assign imem.imem_req  = issue && reset;
    assign imem.imem_addr = imem.imem_req ? pc_q : 32'h0;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed and randomized bench for fetch_unit with a queue reference model
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        branch_taken_in = 1'b0;
    logic [31:0] branch_target_in = 32'h0;
    logic        sel_stall = 1'b0;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        valid_out;
    logic        pred_taken_out;

    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clk              (clk),
        .reset            (reset),
        .imem             (bus),
        .branch_taken_in  (branch_taken_in),
        .branch_target_in (branch_target_in),
        .sel_stall        (sel_stall),
        .instr_out        (instr_out),
        .pc_out           (pc_out),
        .valid_out        (valid_out),
        .pred_taken_out   (pred_taken_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;

    int          n_cmp = 0;
    int          n_bad = 0;

    ent_t        q[$];
    logic [31:0] exp_addr = RESET_PC;
    logic [31:0] req_pc = 32'h0;
    bit          outstanding = 1'b0;
    bit          dropping = 1'b0;

    bit          mem_pend = 1'b0;
    bit          stale = 1'b0;
    int          mem_cnt = 0;
    int          mem_lat = 1;
    logic [31:0] mem_addr = 32'h0;

    bit          s_req;
    logic [31:0] s_addr;
    bit          s_valid;
    logic [31:0] s_pc;
    bit          s_pred;

    function automatic logic [31:0] word(input logic [31:0] a);
        logic [31:0] h;
        if (a == 32'h20) return 32'hEAFF_FFFE;
        h = a * 32'h9E37_79B1;
        h = h ^ (h >> 15) ^ 32'h5BD1_E995;
        if (a >= 32'h1000 && a < 32'h1_0000 && h[2:0] == 3'd0)
            return {8'hEA, 20'hFFFFF, h[7:4]};
        if (h[31:24] == 8'hEA) h[31] = 1'b0;
        return h;
    endfunction

    function automatic bit pred_of(input logic [31:0] w);
`ifdef FETCH_STATIC_PREDICT_EN
        return (w[31:28] == 4'hE) && (w[27:24] == 4'hA) && w[23];
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] tgt_of(input logic [31:0] pc, input logic [31:0] w);
        return pc + 32'd8 + {{6{w[23]}}, w[23:0], 2'b00};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit br, input logic [31:0] tgt, input bit stall);
        bit          rv;
        logic [31:0] rd;
        bit          pop;
        bit          exp_req;
        bit          push;
        ent_t        e;
        @(negedge clk);
        branch_taken_in  = br;
        branch_target_in = tgt;
        sel_stall        = stall;
        rv = 1'b0;
        rd = 32'h0;
        if (stale) begin
            rv    = 1'b1;
            rd    = 32'hDEAD_BEEF;
            stale = 1'b0;
        end else if (mem_pend) begin
            if (mem_cnt <= 1) begin
                rv       = 1'b1;
                rd       = word(mem_addr);
                mem_pend = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        bus.imem_rvalid = rv;
        bus.imem_rdata  = rd;
        #1;
        pop     = (q.size() > 0) && !stall && !br;
        exp_req = !outstanding && !br && ((q.size() - int'(pop)) < 2);
        chk("imem_req", bus.imem_req, exp_req);
        if (exp_req) chk("imem_addr", bus.imem_addr, exp_addr);
        chk("valid_out", valid_out, q.size() > 0);
        if (q.size() > 0) begin
            chk("pc_out", pc_out, q[0].pc);
            chk("instr_out", instr_out, q[0].instr);
            chk("pred_taken_out", pred_taken_out, q[0].pred);
        end
        s_req   = bus.imem_req;
        s_addr  = bus.imem_addr;
        s_valid = valid_out;
        s_pc    = pc_out;
        s_pred  = pred_taken_out;
        if (bus.imem_req) begin
            mem_pend = 1'b1;
            mem_addr = bus.imem_addr;
            mem_cnt  = (mem_lat > 0) ? mem_lat : int'($urandom_range(1, 3));
        end
        push = rv && outstanding && !dropping && !br;
        if (rv && outstanding) begin
            outstanding = 1'b0;
            dropping    = 1'b0;
        end
        if (br) begin
            q.delete();
            exp_addr = tgt;
            if (outstanding) dropping = 1'b1;
        end else begin
            if (pop) void'(q.pop_front());
            if (push) begin
                e.pc    = req_pc;
                e.instr = rd;
                e.pred  = pred_of(rd);
                q.push_back(e);
                if (e.pred) exp_addr = tgt_of(req_pc, rd);
            end
            if (exp_req) begin
                outstanding = 1'b1;
                dropping    = 1'b0;
                req_pc      = exp_addr;
                exp_addr    = exp_addr + 32'd4;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset            = 1'b0;
        branch_taken_in  = 1'b0;
        sel_stall        = 1'b0;
        bus.imem_rvalid  = 1'b0;
        bus.imem_rdata   = 32'h0;
        #1;
        chk("rst_imem_req", bus.imem_req, 1'b0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_valid_out", valid_out, 1'b0);
        chk("rst_instr_out", instr_out, 32'h0);
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_pred_out", pred_taken_out, 1'b0);
        stale       = mem_pend;
        mem_pend    = 1'b0;
        q.delete();
        outstanding = 1'b0;
        dropping    = 1'b0;
        exp_addr    = RESET_PC;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic wait_req(input string tag, output logic [31:0] a);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            got = s_req;
        end
        chk({tag, "_timeout"}, got, 1'b1);
        a = s_addr;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] exp_next;
        bit          got;

        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0;

        // Sequential fetch from reset with single-cycle memory.
        mem_lat = 1;
        do_reset();
        wait_req("seq0", a);
        chk("seq_addr0", a, 32'h0);
        wait_req("seq1", a);
        chk("seq_addr1", a, 32'h4);
        wait_req("seq2", a);
        chk("seq_addr2", a, 32'h8);

        // Decode stall fills the queue and stops requests.
        do_reset();
        repeat (3) cycle(1'b0, 32'h0, 1'b0);
        repeat (6) cycle(1'b0, 32'h0, 1'b1);
        chk("stall_head_pc", s_pc, 32'h4);
        chk("stall_valid", s_valid, 1'b1);
        chk("stall_no_req", s_req, 1'b0);
        repeat (4) cycle(1'b0, 32'h0, 1'b0);

        // Redirect while the 0x8 request is outstanding.
        mem_lat = 2;
        do_reset();
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            wait_req("drop_seek", a);
            got = (a == 32'h8);
        end
        chk("drop_seek_found", got, 1'b1);
        cycle(1'b1, 32'h100, 1'b0);
        wait_req("drop_next", a);
        chk("drop_next_addr", a, 32'h100);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            cycle(1'b0, 32'h0, 1'b0);
            got = s_valid;
        end
        chk("drop_first_valid", got, 1'b1);
        chk("drop_first_pc", s_pc, 32'h100);

        // Redirect coinciding with the response.
        mem_lat = 1;
        wait_req("coin", a);
        cycle(1'b1, 32'h200, 1'b0);
        cycle(1'b0, 32'h0, 1'b1);
        chk("coin_empty", s_valid, 1'b0);

        // Backward branch word at 0x20.
        cycle(1'b1, 32'h20, 1'b0);
        wait_req("bp_first", a);
        chk("bp_first_addr", a, 32'h20);
        wait_req("bp_next", a);
`ifdef FETCH_STATIC_PREDICT_EN
        exp_next = 32'h20;
`else
        exp_next = 32'h24;
`endif
        chk("bp_next_addr", a, exp_next);
        chk("bp_head_pc", s_pc, 32'h20);
        chk("bp_pred", s_pred, pred_of(32'hEAFF_FFFE));

        // Address wrap at the top of the space.
        cycle(1'b1, 32'hFFFF_FFF8, 1'b0);
        wait_req("wrap0", a);
        chk("wrap_addr0", a, 32'hFFFF_FFF8);
        wait_req("wrap1", a);
        chk("wrap_addr1", a, 32'hFFFF_FFFC);
        wait_req("wrap2", a);
        chk("wrap_addr2", a, 32'h0000_0000);

        // Reset pulsed while a request is outstanding; stale response must be ignored.
        mem_lat = 3;
        wait_req("midwait", a);
        cycle(1'b0, 32'h0, 1'b0);
        do_reset();
        cycle(1'b0, 32'h0, 1'b0);
        chk("post_rst_req", s_req, 1'b1);
        chk("post_rst_addr", s_addr, RESET_PC);

        // Randomized traffic against the reference model.
        mem_lat = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                cycle(($urandom_range(0, 19) == 0),
                      32'h1000 + ($urandom_range(0, 4095) << 2),
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset; 0 = reset asserted.
REQ-004 SHALL have port imem_req, output, 1, instruction memory request; accepted by memory in the cycle it is high.
REQ-005 SHALL have port imem_addr, output, 32, word-aligned request address, valid while imem_req=1.
REQ-006 SHALL have port imem_rvalid, input, 1, response strobe, at least 1 cycle after the request.
REQ-007 SHALL have port imem_rdata, input, 32, instruction word, valid with imem_rvalid.
REQ-008 SHALL have port branch_taken_in, input, 1, redirect from the execute stage.
REQ-009 SHALL have port branch_target_in, input, 32, redirect address, sampled with branch_taken_in.
REQ-010 SHALL have port sel_stall, input, 1, decode stall; head entry is held while high.
REQ-011 SHALL have port instr_out, output, 32, head instruction to decode.
REQ-012 SHALL have port pc_out, output, 32, address of instr_out.
REQ-013 SHALL have port valid_out, output, 1, head entry valid.
REQ-014 SHALL have port pred_taken_out, output, 1, head entry was predicted taken.

Function
REQ-015 SHALL hold a 2-entry FIFO of {instr, pc, pred}; outputs SHALL show the head entry; valid_out=1 iff count>0.
REQ-016 SHALL pop the head when valid_out=1 and sel_stall=0.
REQ-017 SHALL run FSM IDLE (nothing outstanding), WAIT (1 outstanding, keep), DROP (1 outstanding, discard).
REQ-018 In IDLE, with no redirect and count<2 after this cycle's pop, SHALL assert imem_req with imem_addr=pc_q, latch req_pc=pc_q, set pc_q=pc_q+4, and go to WAIT.
REQ-019 SHALL never have more than one request outstanding.
REQ-020 In WAIT, on imem_rvalid SHALL push {imem_rdata, req_pc, pred} and go to IDLE; a push and a pop in the same cycle SHALL both take effect.
REQ-021 In DROP, on imem_rvalid SHALL discard the data and go to IDLE.
REQ-022 On branch_taken_in=1, SHALL flush the FIFO (valid_out=0 next cycle) and set pc_q=branch_target_in.
REQ-023 On that redirect, SHALL go WAIT->DROP, stay DROP->DROP, or stay IDLE; no request SHALL issue that cycle.
REQ-024 On redirect coinciding with imem_rvalid in WAIT, SHALL discard the response and go to IDLE.
REQ-025 Redirect SHALL take priority over prediction, pop and sequential increment, including while sel_stall=1.
REQ-026 Addresses SHALL wrap modulo 2^32; pc_q=32'hFFFF_FFFC SHALL advance to 32'h0000_0000.

Reset
REQ-027 While reset=0: pc_q=RESET_PC, FSM=IDLE, count=0, imem_req=0, imem_addr=0, valid_out=0, instr_out=0, pc_out=0, pred_taken_out=0.
REQ-028 Reset asserted mid-request SHALL drop the outstanding request.
REQ-029 A response arriving in the first cycles after reset release SHALL be ignored, since the FSM is IDLE.
REQ-030 The first request SHALL issue in the first clock after reset deasserts.

Configuration
REQ-031 With FETCH_STATIC_PREDICT_EN defined, a pushed word SHALL set pred=1 when instr[31:28]=4'b1110, instr[27:24]=4'b1010 and instr[23]=1 (unconditional backward B).
REQ-032 For such a word, pc_q SHALL become req_pc+8+(sign-extended instr[23:0]<<2) in the push cycle.
REQ-033 Without FETCH_STATIC_PREDICT_EN, pred SHALL always be 0, pred_taken_out SHALL be tied 0, and fetch SHALL be purely sequential.

Verification
REQ-034 Reset release, memory latency 1, sel_stall=0 -> imem_addr 0x0, 0x4, 0x8 on successive requests; pc_out follows in the same order.
REQ-035 sel_stall=1 for 6 cycles -> count saturates at 2, imem_req=0 while full, and the head stays at pc 0x4 unchanged.
REQ-036 Redirect to 0x100 while a request to 0x8 is outstanding -> the 0x8 response is discarded, the next imem_addr is 0x100, and the first pc_out is 0x100.
REQ-037 Redirect in the same cycle as imem_rvalid -> no push; the FIFO is empty next cycle.
REQ-038 With FETCH_STATIC_PREDICT_EN, word 0xEAFFFFFE at pc 0x20 -> pred_taken_out=1 and the next imem_addr is 0x20; without the macro, the next imem_addr is 0x24.
REQ-039 reset pulsed low mid-WAIT -> all outputs are 0 immediately, and after release imem_addr=RESET_PC.
